// File: rtl/prefix_addsub_pipe_pkg.sv
// prefix_addsub_pipe_pkg: shared gp pair type, clog2 helper and default prefix depth for the add/sub pipeline
package prefix_addsub_pipe_pkg;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int LEVELS = clog2(16);
endpackage

// File: rtl/prefix_addsub_pipe_prefix_level.sv
// prefix_level: one Kogge-Stone level, gp_in -> gp_out combining each position with the one DIST below
module prefix_level
  import prefix_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST = 1
) (
  input  gp_t [WIDTH-1:0] gp_in,
  output gp_t [WIDTH-1:0] gp_out
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_b
    if (i < DIST) begin : g_pass
      assign gp_out[i] = gp_in[i];
    end else begin : g_op
      assign gp_out[i] = {gp_in[i].g | gp_in[i].p & gp_in[i-DIST].g, gp_in[i].p & gp_in[i-DIST].p};
    end
  end
endmodule

// File: rtl/prefix_addsub_pipe.sv
// prefix_addsub_pipe: pipelined Kogge-Stone add/sub; in: valid/ready,a,b,cin,sub,tag; out: valid/ready,sum{cout,s},ovf,zero,tag
module prefix_addsub_pipe
  import prefix_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PIPE = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LV = clog2(WIDTH);
  logic stall, v0, c_r, fv, fm, cout;
  logic [WIDTH-1:0] a_r, b_r, px, fp, cy, s, unused_p;
  logic [TAG_W-1:0] t0, ft;
  gp_t [WIDTH-1:0] gp0, pf;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  always_ff @(posedge clk)
    if (rst) v0 <= 1'b0;
    else if (!stall) begin
      v0 <= in_valid;
      a_r <= in_a;
      b_r <= in_sub ? ~in_b : in_b;
      c_r <= in_sub ^ in_cin;
      t0 <= in_tag;
    end
  assign px = a_r ^ b_r;
  always_comb begin
    gp0[0] = {c_r, 1'b0};
    for (int i = 1; i < WIDTH; i++) gp0[i] = {a_r[i-1] & b_r[i-1], px[i-1]};
  end
  for (genvar k = 0; k < LV; k++) begin : g_lv
    gp_t [WIDTH-1:0] gi, gc, go;
    logic [WIDTH-1:0] pi, po;
    logic mi, mo, vi, vo;
    logic [TAG_W-1:0] ti, tq;
    if (k == 0) begin : g_first
      assign {vi, gi, pi, mi, ti} = {v0, gp0, px, a_r[WIDTH-1] & b_r[WIDTH-1], t0};
    end else begin : g_next
      assign {vi, gi, pi, mi, ti} = {g_lv[k-1].vo, g_lv[k-1].go, g_lv[k-1].po, g_lv[k-1].mo, g_lv[k-1].tq};
    end
    prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (.gp_in(gi), .gp_out(gc));
    if (PIPE != 0 || k == LV - 1) begin : g_reg
      always_ff @(posedge clk)
        if (rst) vo <= 1'b0;
        else if (!stall) begin
          vo <= vi;
          go <= gc;
          po <= pi;
          mo <= mi;
          tq <= ti;
        end
    end else begin : g_comb
      assign {vo, go, po, mo, tq} = {vi, gc, pi, mi, ti};
    end
  end
  assign {fv, pf, fp, fm, ft} = {g_lv[LV-1].vo, g_lv[LV-1].go, g_lv[LV-1].po, g_lv[LV-1].mo, g_lv[LV-1].tq};
  always_comb
    for (int i = 0; i < WIDTH; i++) {cy[i], unused_p[i]} = pf[i];
  assign s = fp ^ cy;
  assign cout = fm | fp[WIDTH-1] & cy[WIDTH-1];
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_zero <= 1'b0;
      out_tag <= '0;
    end else if (!stall) begin
      out_valid <= fv;
      if (fv) begin
        out_sum <= {cout, s};
        out_ovf <= cout ^ cy[WIDTH-1];
        out_zero <= ~|s;
        out_tag <= ft;
      end
    end
endmodule
